// File: rtl/mem_pkg.sv
// Shared types for the memory reservation station: entry layout, default widths
// and the issue-readiness rule shared by the station and anything inspecting entries.
package mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ROB_W  = 6;
    localparam int DEF_IMM_W  = 12;

    typedef struct packed {
        logic                  valid;
        logic                  is_load;
        logic                  is_store;
        logic [DEF_ROB_W-1:0]  rob;
        logic [DEF_IMM_W-1:0]  imm;
        logic                  base_rdy;
        logic [DEF_ROB_W-1:0]  base_tag;
        logic [DEF_DATA_W-1:0] base_val;
        logic                  data_rdy;
        logic [DEF_ROB_W-1:0]  data_tag;
        logic [DEF_DATA_W-1:0] data_val;
    } rs_entry_t;

    // Loads only need the base; stores also need their data operand.
    function automatic logic op_ready(input rs_entry_t e);
        return e.valid && e.base_rdy && (e.is_load || (e.is_store && e.data_rdy));
    endfunction

endpackage

// File: rtl/mem_rs_agu.sv
// Address generation: base plus sign-extended immediate, wrapping at 2^ADDR_W.
// Purely combinational, no backpressure.
module agu #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 12
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [IMM_W-1:0]  i_imm,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_imm_sx;

    assign w_imm_sx = {{(ADDR_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
    assign o_addr   = i_base + w_imm_sx;

endmodule

// File: rtl/mem_rs.sv
// In-order load/store reservation station with CDB wakeup; issues the oldest ready op, one
// per cycle, registered (dispatch->issue 1 cycle). Upstream stalls on o_disp_ready; LSU never stalls.
module mem_rs
    import mem_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_disp_valid,
    output logic                     o_disp_ready,
    input  logic                     i_disp_is_load,
    input  logic                     i_disp_is_store,
    input  logic [ROB_W-1:0]         i_disp_rob,
    input  logic [IMM_W-1:0]         i_disp_imm,
    input  logic                     i_disp_base_rdy,
    input  logic [ROB_W-1:0]         i_disp_base_tag,
    input  logic [DATA_W-1:0]        i_disp_base_val,
    input  logic                     i_disp_data_rdy,
    input  logic [ROB_W-1:0]         i_disp_data_tag,
    input  logic [DATA_W-1:0]        i_disp_data_val,
    input  logic                     i_cdb_valid,
    input  logic [ROB_W-1:0]         i_cdb_tag,
    input  logic [DATA_W-1:0]        i_cdb_data,
    input  logic                     i_flush,
    output logic                     o_issue_valid,
    output logic                     o_issue_is_load,
    output logic                     o_issue_is_store,
    output logic [ROB_W-1:0]         o_issue_rob,
    output logic [ADDR_W-1:0]        o_issue_addr,
    output logic [DATA_W-1:0]        o_issue_store_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rs_entry_t          r_ent [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               r_issue_valid;
    logic               r_issue_is_load;
    logic               r_issue_is_store;
    logic [ROB_W-1:0]   r_issue_rob;
    logic [ADDR_W-1:0]  r_issue_addr;
    logic [DATA_W-1:0]  r_issue_store_data;

    rs_entry_t          w_head_ent;
    rs_entry_t          w_new_ent;
    logic               w_accept;
    logic               w_fire;
    logic               w_base_hit;
    logic               w_data_hit;
    logic [ADDR_W-1:0]  w_addr;

    assign o_disp_ready = (r_count != CNT_W'(DEPTH));
    assign w_accept     = i_disp_valid && o_disp_ready && !i_flush;
    assign w_head_ent   = r_ent[r_head];
    assign w_fire       = op_ready(w_head_ent);
    assign w_base_hit   = i_cdb_valid && (i_cdb_tag == i_disp_base_tag);
    assign w_data_hit   = i_cdb_valid && (i_cdb_tag == i_disp_data_tag);

    // A same-cycle CDB broadcast is folded into the entry being written.
    always_comb begin
        w_new_ent          = '0;
        w_new_ent.valid    = 1'b1;
        w_new_ent.is_load  = i_disp_is_load;
        w_new_ent.is_store = i_disp_is_store;
        w_new_ent.rob      = i_disp_rob;
        w_new_ent.imm      = i_disp_imm;
        w_new_ent.base_tag = i_disp_base_tag;
        w_new_ent.base_rdy = i_disp_base_rdy || w_base_hit;
        w_new_ent.base_val = i_disp_base_rdy ? i_disp_base_val : i_cdb_data;
        w_new_ent.data_tag = i_disp_data_tag;
        w_new_ent.data_rdy = i_disp_is_load || i_disp_data_rdy || w_data_hit;
        w_new_ent.data_val = i_disp_data_rdy ? i_disp_data_val : i_cdb_data;
    end

    agu #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W)
    ) u_agu (
        .i_base (w_head_ent.base_val),
        .i_imm  (w_head_ent.imm),
        .o_addr (w_addr)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_ent[i].valid && i_cdb_valid) begin
                    if (!r_ent[i].base_rdy && (r_ent[i].base_tag == i_cdb_tag)) begin
                        r_ent[i].base_rdy <= 1'b1;
                        r_ent[i].base_val <= i_cdb_data;
                    end
                    if (!r_ent[i].data_rdy && (r_ent[i].data_tag == i_cdb_tag)) begin
                        r_ent[i].data_rdy <= 1'b1;
                        r_ent[i].data_val <= i_cdb_data;
                    end
                end
            end
            if (w_fire) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            // Tail never aliases a firing head: they coincide only when empty or full.
            if (w_accept) begin
                r_ent[r_tail] <= w_new_ent;
                r_tail        <= r_tail + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_fire);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_issue_valid      <= 1'b0;
            r_issue_is_load    <= 1'b0;
            r_issue_is_store   <= 1'b0;
            r_issue_rob        <= '0;
            r_issue_addr       <= '0;
            r_issue_store_data <= '0;
        end else if (i_flush) begin
            r_issue_valid <= 1'b0;
        end else begin
            r_issue_valid <= w_fire;
            if (w_fire) begin
                r_issue_is_load    <= w_head_ent.is_load;
                r_issue_is_store   <= w_head_ent.is_store;
                r_issue_rob        <= w_head_ent.rob;
                r_issue_addr       <= w_addr;
                r_issue_store_data <= w_head_ent.is_store ? w_head_ent.data_val : '0;
            end
        end
    end

    assign o_issue_valid      = r_issue_valid;
    assign o_issue_is_load    = r_issue_is_load;
    assign o_issue_is_store   = r_issue_is_store;
    assign o_issue_rob        = r_issue_rob;
    assign o_issue_addr       = r_issue_addr;
    assign o_issue_store_data = r_issue_store_data;
    assign o_count            = r_count;

endmodule

// File: tb/tb_mem_rs.sv
// Bench for mem_rs: directed scenarios followed by random traffic, all checked each cycle
// against a queue-based model of an in-order reservation station.
module tb_mem_rs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid, disp_is_load, disp_is_store;
    logic [5:0]  disp_rob, disp_base_tag, disp_data_tag, cdb_tag;
    logic [11:0] disp_imm;
    logic        disp_base_rdy, disp_data_rdy, cdb_valid, flush;
    logic [31:0] disp_base_val, disp_data_val, cdb_data;
    logic        disp_ready, issue_valid, issue_is_load, issue_is_store;
    logic [5:0]  issue_rob;
    logic [31:0] issue_addr, issue_store_data;
    logic [3:0]  count;

    mem_rs u_dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
        .i_disp_is_load(disp_is_load), .i_disp_is_store(disp_is_store),
        .i_disp_rob(disp_rob), .i_disp_imm(disp_imm),
        .i_disp_base_rdy(disp_base_rdy), .i_disp_base_tag(disp_base_tag), .i_disp_base_val(disp_base_val),
        .i_disp_data_rdy(disp_data_rdy), .i_disp_data_tag(disp_data_tag), .i_disp_data_val(disp_data_val),
        .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
        .i_flush(flush),
        .o_issue_valid(issue_valid), .o_issue_is_load(issue_is_load), .o_issue_is_store(issue_is_store),
        .o_issue_rob(issue_rob), .o_issue_addr(issue_addr), .o_issue_store_data(issue_store_data),
        .o_count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [5:0]  rob;
        logic [11:0] imm;
        logic        brdy;
        logic [5:0]  btag;
        logic [31:0] bval;
        logic        drdy;
        logic [5:0]  dtag;
        logic [31:0] dval;
    } op_t;

    op_t         q[$];
    logic        e_iv, e_ld, e_st;
    logic [5:0]  e_rob;
    logic [31:0] e_addr, e_sd;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        e_iv = 0; e_ld = 0; e_st = 0; e_rob = 0; e_addr = 0; e_sd = 0;
    endtask

    // Behaviour at one clock edge, from the values driven before it.
    task automatic model_edge();
        op_t n;
        bit  acc, fire;
        if (flush) begin
            q.delete();
            e_iv = 0;
            return;
        end
        acc  = disp_valid && (q.size() < 8);
        fire = (q.size() > 0) && q[0].brdy && (q[0].is_load || q[0].drdy);
        e_iv = fire;
        if (fire) begin
            e_ld   = q[0].is_load;
            e_st   = !q[0].is_load;
            e_rob  = q[0].rob;
            e_addr = q[0].bval + int'($signed(q[0].imm));
            e_sd   = q[0].is_load ? 32'd0 : q[0].dval;
            void'(q.pop_front());
        end
        if (cdb_valid) begin
            foreach (q[i]) begin
                if (!q[i].brdy && q[i].btag == cdb_tag) begin q[i].brdy = 1; q[i].bval = cdb_data; end
                if (!q[i].drdy && q[i].dtag == cdb_tag) begin q[i].drdy = 1; q[i].dval = cdb_data; end
            end
        end
        if (acc) begin
            n.is_load = disp_is_load;
            n.rob = disp_rob;
            n.imm = disp_imm;
            n.btag = disp_base_tag;
            n.dtag = disp_data_tag;
            n.brdy = disp_base_rdy || (cdb_valid && cdb_tag == disp_base_tag);
            n.bval = disp_base_rdy ? disp_base_val : cdb_data;
            n.drdy = disp_data_rdy || (cdb_valid && cdb_tag == disp_data_tag);
            n.dval = disp_data_rdy ? disp_data_val : cdb_data;
            q.push_back(n);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".count"}, 32'(count), 32'(q.size()));
        chk({ctx, ".disp_ready"}, 32'(disp_ready), 32'(q.size() != 8));
        chk({ctx, ".issue_valid"}, 32'(issue_valid), 32'(e_iv));
        chk({ctx, ".issue_is_load"}, 32'(issue_is_load), 32'(e_ld));
        chk({ctx, ".issue_is_store"}, 32'(issue_is_store), 32'(e_st));
        chk({ctx, ".issue_rob"}, 32'(issue_rob), 32'(e_rob));
        chk({ctx, ".issue_addr"}, issue_addr, e_addr);
        chk({ctx, ".issue_store_data"}, issue_store_data, e_sd);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic idle();
        disp_valid = 0; disp_is_load = 0; disp_is_store = 0; disp_rob = 0; disp_imm = 0;
        disp_base_rdy = 0; disp_base_tag = 0; disp_base_val = 0;
        disp_data_rdy = 0; disp_data_tag = 0; disp_data_val = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
    endtask

    task automatic disp(input logic ld, input logic [5:0] rob, input logic [11:0] imm,
                        input logic brdy, input logic [5:0] btag, input logic [31:0] bval,
                        input logic drdy, input logic [5:0] dtag, input logic [31:0] dval);
        disp_valid = 1; disp_is_load = ld; disp_is_store = !ld; disp_rob = rob; disp_imm = imm;
        disp_base_rdy = brdy; disp_base_tag = btag; disp_base_val = bval;
        disp_data_rdy = drdy; disp_data_tag = dtag; disp_data_val = dval;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1; cdb_tag = tag; cdb_data = data;
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        #1;
        check_all("reset");
        #2 rst_n = 1;

        // Ready load: addr 0x1000 - 4
        disp(1, 5, 12'hFFC, 1, 0, 32'h1000, 0, 0, 0);
        step("rl_disp");
        idle();
        step("rl_issue");
        chk("rl.valid", 32'(issue_valid), 1);
        chk("rl.addr", issue_addr, 32'h0000_0FFC);
        chk("rl.rob", 32'(issue_rob), 5);
        chk("rl.is_load", 32'(issue_is_load), 1);
        step("rl_after");

        // Blocked store ahead of a ready load, released by CDB
        disp(0, 3, 12'h010, 0, 7, 0, 1, 0, 32'hAB);
        step("ord_st");
        disp(1, 4, 12'h004, 1, 2, 32'h40, 0, 0, 0);
        step("ord_ld");
        idle();
        step("ord_wait0");
        step("ord_wait1");
        chk("ord.blocked", 32'(issue_valid), 0);
        cdb(7, 32'h200);
        step("ord_cdb");
        idle();
        step("ord_st_issue");
        chk("ord.st_rob", 32'(issue_rob), 3);
        chk("ord.st_addr", issue_addr, 32'h210);
        chk("ord.st_data", issue_store_data, 32'hAB);
        step("ord_ld_issue");
        chk("ord.ld_rob", 32'(issue_rob), 4);
        chk("ord.ld_addr", issue_addr, 32'h44);

        // Dispatch-time bypass
        disp(1, 9, 12'h008, 0, 9, 0, 0, 0, 0);
        cdb(9, 32'h3000);
        step("byp_disp");
        idle();
        step("byp_issue");
        chk("byp.valid", 32'(issue_valid), 1);
        chk("byp.addr", issue_addr, 32'h3008);

        // Fill behind a blocked head, drop the 9th, drain in order
        disp(0, 16, 12'h0, 0, 20, 0, 1, 0, 32'h5);
        step("full_0");
        for (int k = 1; k < 8; k++) begin
            disp(1, 6'(16 + k), 12'(k), 1, 0, 32'h100, 0, 0, 0);
            step("full_fill");
        end
        chk("full.count", 32'(count), 8);
        chk("full.ready", 32'(disp_ready), 0);
        disp(1, 40, 12'h0, 1, 0, 32'h100, 0, 0, 0);
        step("full_drop");
        chk("full.count_after_drop", 32'(count), 8);
        idle();
        cdb(20, 32'h800);
        step("full_cdb");
        idle();
        for (int k = 0; k < 8; k++) begin
            step("full_drain");
            chk("full.drain_valid", 32'(issue_valid), 1);
            chk("full.drain_rob", 32'(issue_rob), 32'(16 + k));
        end
        step("full_empty");
        chk("full.no_dropped_op", 32'(issue_valid), 0);
        for (int k = 0; k < 8; k++) begin
            disp(k[0], 6'(48 + k), 12'(k), 1, 0, 32'h2000, 1, 0, 32'(k));
            step("wrap");
        end
        idle();
        step("wrap_tail");
        step("wrap_idle");

        // Flush while head fires, with a dispatch in the same cycle
        disp(1, 60, 12'h0, 0, 30, 0, 0, 0, 0);
        step("fl_0");
        for (int k = 1; k < 5; k++) begin
            disp(1, 6'(60 + k), 12'h0, 1, 0, 32'h10, 0, 0, 0);
            step("fl_fill");
        end
        idle();
        cdb(30, 32'h900);
        step("fl_cdb");
        idle();
        flush = 1;
        disp(1, 33, 12'h0, 1, 0, 32'h10, 0, 0, 0);
        step("fl_flush");
        chk("fl.valid", 32'(issue_valid), 0);
        chk("fl.count", 32'(count), 0);
        idle();
        step("fl_after");
        chk("fl.discarded", 32'(count), 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 9) < 7)
                disp(1'($urandom_range(0, 1)), 6'($urandom), 12'($urandom),
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 9) < 4) cdb(6'($urandom_range(0, 7)), $urandom);
            flush = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        // Asynchronous reset with work outstanding
        idle();
        disp(1, 11, 12'h0, 0, 12, 0, 0, 0, 0);
        step("ar_fill");
        idle();
        step("ar_hold");
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("ar.count", 32'(count), 0);
        #2 rst_n = 1;
        step("ar_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_rs.md
# mem_rs

In-order memory reservation station and address-generation stage sitting directly upstream of the load/store unit. It accepts load and store micro-ops from dispatch and holds them in a circular buffer. It captures missing source operands from the common data bus (CDB). When the oldest entry has all its operands, it issues that entry to the LSU issue port with address = base + sign-extended immediate. Issue is strictly in program order, because the LSU performs no memory disambiguation.

## Interface
- `DEPTH`, 8: number of entries; must be a power of two, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: operand and data width; must equal `ADDR_W`.
- `ROB_W`, 6: ROB index and tag width.
- `IMM_W`, 12: immediate width, signed.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low. Asserted when 0.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: an entry is free. Equals `count != DEPTH`.
- `disp_is_load` / `disp_is_store` in 1 each: op kind; exactly one is set.
- `disp_rob` in ROB_W: ROB index of the op.
- `disp_imm` in IMM_W: signed offset.
- `disp_base_rdy`, `disp_base_tag` [ROB_W], `disp_base_val` [DATA_W]: base operand ready flag, producer tag, and value.
- `disp_data_rdy`, `disp_data_tag` [ROB_W], `disp_data_val` [DATA_W]: store-data operand. Ignored for loads.
- `cdb_valid` in 1, `cdb_tag` in ROB_W, `cdb_data` in DATA_W: result broadcast.
- `flush` in 1: discard all entries.
- `issue_valid`, `issue_is_load`, `issue_is_store` out 1 each: issue to the LSU.
- `issue_rob` out ROB_W: ROB index of the issued op.
- `issue_addr` out ADDR_W: computed address.
- `issue_store_data` out DATA_W: store data.
- `count` out $clog2(DEPTH)+1: number of occupied entries.

## Operation
- **Storage.** Circular buffer with `head` and `tail` pointers of $clog2(DEPTH) bits. Pointers wrap naturally at DEPTH. Each entry has a valid bit.
- **Dispatch.** An op is accepted when `disp_valid && disp_ready && !flush`. It is written at `tail`, and `tail` increments.
  - When full, dispatch is dropped; the upstream must honour `disp_ready`.
  - `disp_ready` depends on `count` only. It is 0 when full, even in a cycle where the head issues.
- **Wakeup.** Each cycle, for every valid entry with a non-ready operand whose tag equals `cdb_tag` while `cdb_valid`: capture `cdb_data` and set the ready flag.
- **Dispatch-time bypass.** An op being dispatched with `rdy=0` and a tag matching the CDB in the same cycle is written already ready, holding `cdb_data`.
- **Fire condition.** `fire` = head entry valid, base ready, and (load, or store with data ready). Only stored (registered) flags count; a CDB hit in the same cycle does not make the head fire that cycle.
- **Issue.** On `fire`:
  - the issue registers load the head fields;
  - `issue_addr = base + sign_extend(imm)`, modulo 2^ADDR_W;
  - `issue_store_data` = data operand for stores, 0 for loads;
  - the head entry is invalidated and `head` increments.
- **Idle issue.** When not firing, `issue_valid` is 0 and the other issue outputs hold their previous values.
- **Blocking.** A non-ready head blocks every younger entry, even ready ones.
- **Count.** `count` changes by +1 on dispatch only, −1 on fire only, and is unchanged when both happen.
- **Flush.** Synchronous, with priority over dispatch, wakeup and fire. It clears all valid bits, sets head = tail = 0 and count = 0, and makes `issue_valid` 0 on the next cycle.

## Timing
- **Reset value of every output:** `issue_*` all 0, `count` 0, `disp_ready` 1. Pointers and valid bits are 0.
- **Reset mid-operation:** asserting `rst` at any time empties the buffer immediately, without waiting for a clock edge.
- **Latency, ready at dispatch:** an op dispatched at edge E with all operands ready (at an empty-queue head) shows `issue_valid`=1 after edge E+1.
- **Latency, via CDB:** a CDB wakeup captured at edge E allows issue at edge E+1. `issue_valid` is visible after E+1.
- **Throughput:** at most one issue per cycle. Back-to-back ready entries issue on consecutive cycles.
- **No backpressure:** `issue_valid` is a single-cycle pulse per op.

## Structure
- Package `mem_pkg`:
  - `rs_entry_t` struct: valid, is_load, is_store, rob, imm, base_rdy/tag/val, data_rdy/tag/val;
  - default `IMM_W`.
- Sub-module `agu`: combinational adder taking base and imm (sign-extended) and producing addr. Instantiated once on the head entry.
- All other logic lives in `mem_rs`.

## Test plan
- **Reset:** `rst`=0 mid-stream → `count`=0, `issue_valid`=0, `disp_ready`=1 immediately.
- **Ready load:** dispatch load, rob=5, base=0x1000 ready, imm=0xFFC (−4) → 2 cycles later `issue_valid`=1, `issue_addr`=0x0FFC, `issue_rob`=5, `issue_is_load`=1.
- **CDB wakeup and ordering:** dispatch store (rob=3, base tag 7 not ready, data 0xAB ready), then a ready load (rob=4) → no issue. Then `cdb_valid`, tag 7, data 0x200 → store issues with addr 0x200 + imm and data 0xAB, and the load issues on the next cycle.
- **Dispatch/CDB bypass:** dispatch with base tag 9 not ready in the same cycle as a CDB broadcast of tag 9 → the entry issues with no further broadcast needed.
- **Full and wrap:** dispatch 8 ready ops while the head is blocked → `count`=8, `disp_ready`=0, a 9th `disp_valid` is dropped. Unblock the head → 8 ops issue in order. Dispatch 8 more → pointers wrap and order is preserved.
- **Flush:** flush with 5 entries while the head fires → the next cycle has `issue_valid`=0 and `count`=0, and a dispatch in the flush cycle is discarded.
